// File: rtl/riscv_div_unit.sv
// RV32M multi-cycle divider (DIV/DIVU/REM/REMU), radix-2 restoring, EX stage.
// Define DIV_EARLY_OUT_EN to finish |dividend| < |divisor| in one cycle.
module riscv_div_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [1:0]      op,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic [4:0]      rd_in,
   input  logic            flush,
   output logic            busy,
   output logic            valid_out,
   output logic [XLEN-1:0] result,
   output logic [4:0]      rd_out
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   localparam logic [XLEN-1:0] MINV = {1'b1, {(XLEN-1){1'b0}}};

   state_t            state;
   logic              rem_sel;
   logic [4:0]        rd_q;
   logic [XLEN-1:0]   dvsr;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   quo;
   logic [CNT_W-1:0]  cnt;
   logic              neg_q;
   logic              neg_r;

   logic              is_signed;
   logic [XLEN-1:0]   abs1;
   logic [XLEN-1:0]   abs2;
   logic              div_zero;
   logic              ovf;
   logic              early;
   logic              fast;
   logic [XLEN-1:0]   fast_q;
   logic [XLEN-1:0]   fast_r;
   logic [XLEN-1:0]   fast_res;

   logic [XLEN:0]     shl;
   logic              ge;
   logic [XLEN-1:0]   diff;
   logic [XLEN-1:0]   rem_nx;
   logic [XLEN-1:0]   quo_nx;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;

   assign is_signed = ~op[0];
   assign abs1 = (is_signed && rs1_data[XLEN-1]) ? -rs1_data : rs1_data;
   assign abs2 = (is_signed && rs2_data[XLEN-1]) ? -rs2_data : rs2_data;
   assign div_zero = (rs2_data == '0);
   assign ovf = is_signed && (rs1_data == MINV) && (rs2_data == '1);

`ifdef DIV_EARLY_OUT_EN
   assign early = !div_zero && (abs1 < abs2);
`else
   assign early = 1'b0;
`endif

   assign fast = div_zero | ovf | early;

   // Divide-by-zero and overflow outrank the early-out case.
   always_comb begin
      fast_q = '1;
      fast_r = rs1_data;
      if (div_zero) begin
         fast_q = '1;
         fast_r = rs1_data;
      end else if (ovf) begin
         fast_q = MINV;
         fast_r = '0;
      end else if (early) begin
         fast_q = '0;
         fast_r = rs1_data;
      end
   end

   assign fast_res = op[1] ? fast_r : fast_q;

   // One restoring step on the magnitudes; the shifted partial remainder
   // needs one extra bit before the trial subtract.
   assign shl    = {rem, quo[XLEN-1]};
   assign ge     = (shl >= {1'b0, dvsr});
   assign diff   = shl[XLEN-1:0] - dvsr;
   assign rem_nx = ge ? diff : shl[XLEN-1:0];
   assign quo_nx = {quo[XLEN-2:0], ge};
   assign q_fix  = neg_q ? -quo_nx : quo_nx;
   assign r_fix  = neg_r ? -rem_nx : rem_nx;

   assign busy      = (state != IDLE);
   assign valid_out = (state == DONE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         rem_sel <= 1'b0;
         rd_q    <= '0;
         dvsr    <= '0;
         rem     <= '0;
         quo     <= '0;
         cnt     <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         result  <= '0;
         rd_out  <= '0;
      end else if (flush) begin
         state <= IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  rem_sel <= op[1];
                  rd_q    <= rd_in;
                  dvsr    <= abs2;
                  quo     <= abs1;
                  rem     <= '0;
                  cnt     <= CNT_W'(XLEN-1);
                  neg_q   <= is_signed &
                             (rs1_data[XLEN-1] ^ rs2_data[XLEN-1]);
                  neg_r   <= is_signed & rs1_data[XLEN-1];
                  if (fast) begin
                     result <= fast_res;
                     rd_out <= rd_in;
                     state  <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               rem <= rem_nx;
               quo <= quo_nx;
               cnt <= cnt - 1'b1;
               if (cnt == '0) begin
                  result <= rem_sel ? r_fix : q_fix;
                  rd_out <= rd_q;
                  state  <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
